// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light encoding and request-FSM state shared with the traffic-light fsm
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED = 2'b00;
    localparam logic [1:0] LIGHT_N   = 2'b01;
    localparam logic [1:0] LIGHT_W   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } req_state_t;

    // Direction index 0 is north, 1 is west.
    function automatic logic [1:0] own_green(input logic dir);
        return dir ? LIGHT_W : LIGHT_N;
    endfunction

endpackage

// File: rtl/req_debounce.sv
// rtl/req_debounce.sv - 2-flop synchronizer plus consecutive-high debounce with one-shot detect
module req_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic detect
);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;

    // Strobe is combinational so the consumer registers it on the edge the count reaches DEB_CYCLES.
    assign detect = sync2 && (cnt == 4'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!sync2) begin
                cnt <= 4'd0;
            end else if (cnt != 4'(DEB_CYCLES)) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_req_gen.sv
// rtl/traffic_req_gen.sv - debounced north/west request pulses with retry until the fsm serves them
import traffic_pkg::*;

module traffic_req_gen #(
    parameter int DEB_CYCLES   = 4,
    parameter int RETRY_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       n_raw,
    input  logic       w_raw,
    input  logic [1:0] light,
    output logic       n,
    output logic       w,
    output logic       n_pend,
    output logic       w_pend
);

    logic [1:0] detect;
    logic [1:0] req;
    logic [1:0] grant;

    req_state_t state_q [2];
    req_state_t state_d [2];
    logic [7:0] retry_q [2];
    logic [7:0] retry_d [2];
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic [1:0] pulse_q;
    logic [1:0] pulse_d;
    logic       toggle_q;
    logic       toggle_d;

    req_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_n (
        .clk    (clk),
        .reset  (reset),
        .raw    (n_raw),
        .detect (detect[0])
    );

    req_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_w (
        .clk    (clk),
        .reset  (reset),
        .raw    (w_raw),
        .detect (detect[1])
    );

    always_comb begin
        req[0] = (state_q[0] == REQ);
        req[1] = (state_q[1] == REQ);
        // toggle_q low favours north; it only moves when both directions contend.
        grant[0] = req[0] && (!req[1] || !toggle_q);
        grant[1] = req[1] && (!req[0] || toggle_q);
        toggle_d = toggle_q ^ (req[0] && req[1]);

        for (int d = 0; d < 2; d++) begin
            state_d[d] = state_q[d];
            retry_d[d] = retry_q[d];
            pend_d[d]  = pend_q[d];
            pulse_d[d] = 1'b0;
            case (state_q[d])
                IDLE: begin
                    if (detect[d] && (light != own_green(d[0]))) begin
                        pend_d[d]  = 1'b1;
                        state_d[d] = REQ;
                    end
                end
                REQ: begin
                    if (grant[d]) begin
                        pulse_d[d] = 1'b1;
                        retry_d[d] = 8'(RETRY_CYCLES);
                        state_d[d] = WAIT;
                    end
                end
                WAIT: begin
                    // Service takes priority over the retry expiring on the same edge.
                    if (light == own_green(d[0])) begin
                        pend_d[d]  = 1'b0;
                        state_d[d] = IDLE;
                    end else begin
                        retry_d[d] = retry_q[d] - 8'd1;
                        if (retry_q[d] == 8'd1) begin
                            state_d[d] = REQ;
                        end
                    end
                end
                default: state_d[d] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= IDLE;
                retry_q[d] <= 8'd0;
            end
            pend_q   <= 2'b00;
            pulse_q  <= 2'b00;
            toggle_q <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= state_d[d];
                retry_q[d] <= retry_d[d];
            end
            pend_q   <= pend_d;
            pulse_q  <= pulse_d;
            toggle_q <= toggle_d;
        end
    end

    assign n      = pulse_q[0];
    assign w      = pulse_q[1];
    assign n_pend = pend_q[0];
    assign w_pend = pend_q[1];

endmodule

// File: tb/tb_traffic_req_gen.sv
// tb/tb_traffic_req_gen.sv - bench for traffic_req_gen against a timing-arithmetic reference model
module tb_traffic_req_gen;

    localparam int DEB   = 4;
    localparam int RETRY = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       n_raw;
    logic       w_raw;
    logic [1:0] light;
    logic       n;
    logic       w;
    logic       n_pend;
    logic       w_pend;

    traffic_req_gen #(.DEB_CYCLES(DEB), .RETRY_CYCLES(RETRY)) dut (
        .clk    (clk),
        .reset  (reset),
        .n_raw  (n_raw),
        .w_raw  (w_raw),
        .light  (light),
        .n      (n),
        .w      (w),
        .n_pend (n_pend),
        .w_pend (w_pend)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: run lengths of raw highs, pending flags and edge-number deadlines.
    bit m_pend [2];
    bit m_fire [2];
    int m_elig [2];
    int m_last [2];
    int r1 [2];
    int r2 [2];
    bit m_tog;
    int k = 0;
    int cur_edge = 0;
    int n_hits[$];
    int w_hits[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp, cur_edge);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 1'b0;
            m_fire[d] = 1'b0;
            m_elig[d] = 0;
            m_last[d] = -1000;
            r1[d] = 0;
            r2[d] = 0;
        end
        m_tog = 1'b0;
    endtask

    task automatic model_step();
        bit raw [2];
        bit det [2];
        bit want [2];
        bit old_pend [2];
        logic [1:0] own;
        raw[0] = n_raw;
        raw[1] = w_raw;
        for (int d = 0; d < 2; d++) begin
            // A run of exactly DEB highs ending two edges ago is what the synchronizer delivers now.
            det[d] = (r2[d] == DEB);
            want[d] = m_pend[d] && (k >= m_elig[d]);
            old_pend[d] = m_pend[d];
            m_fire[d] = 1'b0;
        end
        if (want[0] && want[1]) begin
            if (m_tog) m_fire[1] = 1'b1;
            else       m_fire[0] = 1'b1;
            m_tog = !m_tog;
        end else begin
            m_fire[0] = want[0];
            m_fire[1] = want[1];
        end
        for (int d = 0; d < 2; d++) begin
            own = (d == 0) ? 2'b01 : 2'b10;
            if (m_fire[d]) begin
                m_last[d] = k;
                m_elig[d] = k + RETRY + 1;
            end else if (old_pend[d] && k > m_last[d] && k <= m_last[d] + RETRY && light == own) begin
                m_pend[d] = 1'b0;
            end else if (!old_pend[d] && det[d] && light != own) begin
                m_pend[d] = 1'b1;
                m_elig[d] = k + 1;
                m_last[d] = -1000;
            end
            r2[d] = r1[d];
            r1[d] = raw[d] ? ((r1[d] < 1000) ? r1[d] + 1 : r1[d]) : 0;
        end
        cur_edge = k;
        k++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        chk("n", int'(n), int'(m_fire[0]));
        chk("w", int'(w), int'(m_fire[1]));
        chk("n_pend", int'(n_pend), int'(m_pend[0]));
        chk("w_pend", int'(w_pend), int'(m_pend[1]));
        if (n) n_hits.push_back(cur_edge);
        if (w) w_hits.push_back(cur_edge);
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    function automatic int last_n();
        return (n_hits.size() == 0) ? -1 : n_hits[n_hits.size() - 1];
    endfunction

    function automatic int last_w();
        return (w_hits.size() == 0) ? -1 : w_hits[w_hits.size() - 1];
    endfunction

    int s;
    int nb;
    int wb;

    initial begin
        reset = 1'b0;
        n_raw = 1'b1;
        w_raw = 1'b1;
        light = 2'b00;
        model_reset();

        // Reset held with detectors high.
        ticks(3);
        chk("reset_n", int'(n), 0);
        chk("reset_pend", int'(n_pend | w_pend | w), 0);

        reset = 1'b1;
        w_raw = 1'b0;
        s = k;
        ticks(7);
        chk("first_n_edge", last_n(), s + 6);
        chk("first_n_pend", int'(n_pend), 1);

        // Service on north green clears on the next edge.
        light = 2'b01;
        tick();
        chk("serve_n_pend", int'(n_pend), 0);
        tick();
        light = 2'b00;
        n_raw = 1'b0;
        ticks(4);

        // Detection during own green is ignored.
        nb = n_hits.size();
        light = 2'b01;
        n_raw = 1'b1;
        ticks(8);
        n_raw = 1'b0;
        ticks(3);
        light = 2'b00;
        ticks(2);
        chk("own_green_hits", n_hits.size(), nb);
        chk("own_green_pend", int'(n_pend), 0);

        // Glitch: 3 high, 1 low, 3 high.
        nb = n_hits.size();
        for (int g = 0; g < 7; g++) begin
            n_raw = (g != 3);
            tick();
        end
        n_raw = 1'b0;
        ticks(10);
        chk("glitch_hits", n_hits.size(), nb);
        chk("glitch_pend", int'(n_pend), 0);

        // West retry while north holds green.
        wb = w_hits.size();
        w_raw = 1'b1;
        ticks(7);
        light = 2'b01;
        ticks(20);
        chk("retry_count", w_hits.size() - wb, 3);
        if (w_hits.size() - wb >= 3) begin
            chk("retry_gap1", w_hits[wb + 1] - w_hits[wb], 9);
            chk("retry_gap2", w_hits[wb + 2] - w_hits[wb + 1], 9);
        end
        light = 2'b10;
        tick();
        chk("retry_served", int'(w_pend), 0);
        light = 2'b00;
        w_raw = 1'b0;
        ticks(5);

        // Simultaneous rise: north wins first, then west.
        n_raw = 1'b1;
        w_raw = 1'b1;
        s = k;
        ticks(8);
        chk("sim1_n", last_n(), s + 6);
        chk("sim1_w", last_w(), s + 7);
        light = 2'b01;
        tick();
        light = 2'b10;
        tick();
        light = 2'b00;
        n_raw = 1'b0;
        w_raw = 1'b0;
        ticks(6);
        n_raw = 1'b1;
        w_raw = 1'b1;
        s = k;
        ticks(8);
        chk("sim2_w", last_w(), s + 6);
        chk("sim2_n", last_n(), s + 7);
        light = 2'b10;
        tick();
        light = 2'b01;
        tick();
        light = 2'b00;
        n_raw = 1'b0;
        w_raw = 1'b0;
        ticks(5);
        chk("sim2_pends", int'(n_pend | w_pend), 0);

        // Asynchronous reset while north waits for service.
        n_raw = 1'b1;
        ticks(8);
        chk("mid_pend_before", int'(n_pend), 1);
        reset = 1'b0;
        #1;
        chk("mid_pend_async", int'(n_pend), 0);
        model_reset();
        @(negedge clk);
        ticks(2);
        reset = 1'b1;
        s = k;
        ticks(7);
        chk("mid_restart_n", last_n(), s + 6);
        light = 2'b01;
        tick();
        light = 2'b00;
        n_raw = 1'b0;
        ticks(3);

        // Randomized traffic, including illegal light codes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) n_raw = ~n_raw;
            if ($urandom_range(0, 7) == 0) w_raw = ~w_raw;
            if ($urandom_range(0, 3) == 0) light = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                model_reset();
                ticks(2);
                reset = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
